// File: rtl/five_bit_counter_driver_if.sv
// Bus between the counter driver (master) and a 5-bit up/down counter (slave):
// data/strobe outputs towards the counter and registered value/flag feedback.
interface five_bit_counter_driver_if #(
    parameter int unsigned WIDTH = 5
);
    logic [WIDTH-1:0] in;
    logic             load;
    logic             up;
    logic             down;
    logic [WIDTH-1:0] counter_fb;
    logic             low_fb;
    logic             high_fb;

    modport master (
        output in, load, up, down,
        input  counter_fb, low_fb, high_fb
    );

    modport slave (
        input  in, load, up, down,
        output counter_fb, low_fb, high_fb
    );
endinterface

// File: rtl/five_bit_counter_driver.sv
// Command-side master for a 5-bit up/down counter: loads a start value, then steps it to a target.
// Optional macro COUNTER_DRV_FLAG_CHECK_EN adds a low/high flag consistency check in CHECK.
module five_bit_counter_driver #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       init_val,
    input  logic [WIDTH-1:0]       target,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    five_bit_counter_driver_if.master bus
);

    localparam logic [WIDTH-1:0] MaxVal     = '1;
    localparam logic [5:0]       TimeoutCnt = 6'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCheck,
        StStepUp,
        StStepDn,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] target_q;
    logic [5:0]       step_q;
    logic             load_q;
    logic             up_q;
    logic             down_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic             flag_bad;

`ifdef COUNTER_DRV_FLAG_CHECK_EN
    assign flag_bad = (bus.low_fb  != (bus.counter_fb == '0)) ||
                      (bus.high_fb != (bus.counter_fb == MaxVal));
`else
    logic unused_flags;
    assign unused_flags = bus.low_fb ^ bus.high_fb;
    assign flag_bad     = 1'b0;
`endif

    // All outputs are registered and decoded from the state being entered.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            in_q     <= '0;
            target_q <= '0;
            step_q   <= '0;
            load_q   <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        in_q   <= init_val;
                        step_q <= '0;
                        unique case (mode)
                            2'b00:   target_q <= target;
                            2'b01:   target_q <= '0;
                            2'b10:   target_q <= MaxVal;
                            default: target_q <= init_val;
                        endcase
                        load_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    state_q <= StCheck;
                end
                StCheck: begin
                    if (flag_bad || (bus.counter_fb == target_q) || (step_q == TimeoutCnt)) begin
                        done_q  <= 1'b1;
                        error_q <= flag_bad || (bus.counter_fb != target_q);
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end else if (bus.counter_fb < target_q) begin
                        up_q    <= 1'b1;
                        state_q <= StStepUp;
                    end else begin
                        down_q  <= 1'b1;
                        state_q <= StStepDn;
                    end
                end
                StStepUp, StStepDn: begin
                    if (step_q != 6'h3f) begin
                        step_q <= step_q + 6'd1;
                    end
                    state_q <= StCheck;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in   = in_q;
    assign bus.load = load_q;
    assign bus.up   = up_q;
    assign bus.down = down_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_five_bit_counter_driver.sv
// Directed bench for five_bit_counter_driver: two instances (default and TIMEOUT=10), each
// driving a behavioural registered 5-bit counter.
module tb_five_bit_counter_driver;

    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [4:0] init_val = '0;
    logic [4:0] target = '0;
    logic       force_low = 1'b0;

    logic busy_a, done_a, error_a;
    logic busy_b, done_b, error_b;
    logic [4:0] cnt_a, cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    five_bit_counter_driver_if bus_a ();
    five_bit_counter_driver_if bus_b ();

    five_bit_counter_driver dut_a (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start_a),
        .mode     (mode),
        .init_val (init_val),
        .target   (target),
        .busy     (busy_a),
        .done     (done_a),
        .error    (error_a),
        .bus      (bus_a)
    );

    five_bit_counter_driver #(.TIMEOUT(10)) dut_b (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start_b),
        .mode     (mode),
        .init_val (init_val),
        .target   (target),
        .busy     (busy_b),
        .done     (done_b),
        .error    (error_b),
        .bus      (bus_b)
    );

    // Behavioural counters: registered value, load over up over down.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (bus_a.load)      cnt_a <= bus_a.in;
            else if (bus_a.up)   cnt_a <= cnt_a + 5'd1;
            else if (bus_a.down) cnt_a <= cnt_a - 5'd1;
            if (bus_b.load)      cnt_b <= bus_b.in;
            else if (bus_b.up)   cnt_b <= cnt_b + 5'd1;
            else if (bus_b.down) cnt_b <= cnt_b - 5'd1;
        end
    end

    assign bus_a.counter_fb = cnt_a;
    assign bus_a.low_fb     = (cnt_a == 5'd0) | force_low;
    assign bus_a.high_fb    = (cnt_a == 5'd31);
    assign bus_b.counter_fb = cnt_b;
    assign bus_b.low_fb     = (cnt_b == 5'd0);
    assign bus_b.high_fb    = (cnt_b == 5'd31);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one request and samples every cycle at the falling edge until done (bounded).
    // Returns at the falling edge of the done cycle; done_cyc stays 0 if done never arrives.
    task automatic run_req(input bit sel, input logic [1:0] m, input logic [4:0] iv,
                           input logic [4:0] tv, output int done_cyc, output int ups,
                           output int downs, output int loads, output int load_cyc,
                           output logic err, output logic busy1);
        bit finished;
        @(negedge clock);
        mode = m;
        init_val = iv;
        target = tv;
        if (sel) start_b = 1'b1;
        else     start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        start_b = 1'b0;
        done_cyc = 0;
        ups = 0;
        downs = 0;
        loads = 0;
        load_cyc = 0;
        err = 1'b0;
        busy1 = sel ? busy_b : busy_a;
        finished = 1'b0;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (sel ? bus_b.up : bus_a.up) ups++;
            if (sel ? bus_b.down : bus_a.down) downs++;
            if (sel ? bus_b.load : bus_a.load) begin
                loads++;
                load_cyc = cyc;
            end
            if (sel ? done_b : done_a) begin
                done_cyc = cyc;
                err = sel ? error_b : error_a;
                finished = 1'b1;
            end
        end
    endtask

    int   dc, nu, nd, nl, lc;
    logic er, bz;
    bit   saw_up;

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_error", 32'(error_a), 32'd0);
        chk("rst_in", 32'(bus_a.in), 32'd0);
        chk("rst_strobes", 32'({bus_a.load, bus_a.up, bus_a.down}), 32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        // Load only: init 23
        run_req(1'b0, 2'b11, 5'd23, 5'd0, dc, nu, nd, nl, lc, er, bz);
        chk("ld_busy_c1", 32'(bz), 32'd1);
        chk("ld_loads", 32'(nl), 32'd1);
        chk("ld_load_cyc", 32'(lc), 32'd1);
        chk("ld_done_cyc", 32'(dc), 32'd3);
        chk("ld_error", 32'(er), 32'd0);
        chk("ld_counter", 32'(cnt_a), 32'd23);
        chk("ld_busy_done", 32'(busy_a), 32'd0);

        // Step up: 23 -> 24
        run_req(1'b0, 2'b00, 5'd23, 5'd24, dc, nu, nd, nl, lc, er, bz);
        chk("su_ups", 32'(nu), 32'd1);
        chk("su_downs", 32'(nd), 32'd0);
        chk("su_done_cyc", 32'(dc), 32'd5);
        chk("su_error", 32'(er), 32'd0);
        chk("su_counter", 32'(cnt_a), 32'd24);

        // Sweep low from 22
        run_req(1'b0, 2'b01, 5'd22, 5'd9, dc, nu, nd, nl, lc, er, bz);
        chk("sl_downs", 32'(nd), 32'd22);
        chk("sl_ups", 32'(nu), 32'd0);
        chk("sl_done_cyc", 32'(dc), 32'd47);
        chk("sl_counter", 32'(cnt_a), 32'd0);
        chk("sl_low", 32'(bus_a.low_fb), 32'd1);
        chk("sl_error", 32'(er), 32'd0);

        // Sweep high from 0
        run_req(1'b0, 2'b10, 5'd0, 5'd3, dc, nu, nd, nl, lc, er, bz);
        chk("sh_ups", 32'(nu), 32'd31);
        chk("sh_done_cyc", 32'(dc), 32'd65);
        chk("sh_counter", 32'(cnt_a), 32'd31);
        chk("sh_high", 32'(bus_a.high_fb), 32'd1);
        chk("sh_error", 32'(er), 32'd0);

        // Same sweep on the TIMEOUT=10 instance
        run_req(1'b1, 2'b10, 5'd0, 5'd3, dc, nu, nd, nl, lc, er, bz);
        chk("to_ups", 32'(nu), 32'd10);
        chk("to_done_cyc", 32'(dc), 32'd23);
        chk("to_error", 32'(er), 32'd1);
        chk("to_counter", 32'(cnt_b), 32'd10);

`ifdef COUNTER_DRV_FLAG_CHECK_EN
        force_low = 1'b1;
        run_req(1'b0, 2'b11, 5'd5, 5'd0, dc, nu, nd, nl, lc, er, bz);
        chk("ff_done_cyc", 32'(dc), 32'd3);
        chk("ff_error", 32'(er), 32'd1);
        force_low = 1'b0;
`endif

        // Reset mid-sweep while an up strobe is out
        @(negedge clock);
        mode = 2'b10;
        init_val = 5'd0;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        saw_up = 1'b0;
        for (int i = 0; i < 20 && !saw_up; i++) begin
            @(negedge clock);
            saw_up = bus_a.up;
        end
        chk("rm_reached_up", 32'(saw_up), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_outputs_zero",
            32'({bus_a.in, bus_a.load, bus_a.up, bus_a.down, busy_a, done_a, error_a}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        chk("rm_no_done", 32'(done_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clock);
        chk("rm_idle_after", 32'({busy_a, done_a}), 32'd0);
        run_req(1'b0, 2'b00, 5'd23, 5'd24, dc, nu, nd, nl, lc, er, bz);
        chk("rm_restart_cyc", 32'(dc), 32'd5);
        chk("rm_restart_cnt", 32'(cnt_a), 32'd24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/five_bit_counter_driver.md
# five_bit_counter_driver

Command-side master for the 5-bit up/down counter interface. It drives the counter's `in`, `load`, `up` and `down` pins and reads back `counter`, `low` and `high`. Each request loads a start value, then steps the counter one count at a time until it equals a target. It reports completion or failure to the requesting logic with a busy/done/error handshake. It sits between the control path and the counter instance, and it also serves as the self-checking stimulus source for counter bring-up.

## Interface
Parameters:
- `WIDTH`, 5: counter width. The driver is only defined for 5; `high` corresponds to 31.
- `TIMEOUT`, 40: maximum number of step pulses per request before the driver aborts with error.

Ports:
- `clock`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request strobe; sampled only in IDLE.
- `mode`, in, 2:
  - 00: load `init_val`, then step to `target`.
  - 01: load, then sweep to 0.
  - 10: load, then sweep to 31.
  - 11: load only.
- `init_val`, in, 5: value to load into the counter.
- `target`, in, 5: final value (mode 00 only).
- `busy`, out, 1: a request is in progress.
- `done`, out, 1: one-cycle completion pulse.
- `error`, out, 1: valid only while `done` is high; 1 means the request failed.
- `in`, out, 5: value driven to the counter data input.
- `load`, out, 1: counter load strobe.
- `up`, out, 1: counter increment strobe.
- `down`, out, 1: counter decrement strobe.
- `counter_fb`, in, 5: registered counter value fed back from the counter.
- `low_fb`, in, 1: counter low flag.
- `high_fb`, in, 1: counter high flag.

## Operation
- States: IDLE, LOAD, CHECK, STEP_UP, STEP_DN, DONE.
- Reset values:
  - State is IDLE.
  - `in`, `load`, `up`, `down`, `busy`, `done` and `error` are all 0.
  - The step counter is 0.
- IDLE, on `start=1`:
  - Latch `init_val`, `mode`, and the effective target: `target` for mode 00, 0 for mode 01, 31 for mode 10, `init_val` for mode 11.
  - Clear the step counter and go to LOAD.
  - `start=0`: remain in IDLE.
- LOAD: `load=1` and `in`=latched `init_val` for exactly one cycle, then go to CHECK.
- CHECK evaluates `counter_fb` in this priority order:
  1. `counter_fb` equals the target: go to DONE with no error.
  2. The step counter equals `TIMEOUT`: go to DONE with error.
  3. `counter_fb` < target: go to STEP_UP.
  4. `counter_fb` > target: go to STEP_DN.
- STEP_UP: `up=1` for one cycle; increment the step counter; go to CHECK.
- STEP_DN: `down=1` for one cycle; increment the step counter; go to CHECK.
- DONE: `done=1` and `error`=latched result for one cycle, then go to IDLE.
- `load`, `up` and `down` are mutually exclusive and are decoded from state only. There is no combinational path from `counter_fb`, `low_fb` or `high_fb` to any output.
- `in` holds the last loaded value outside LOAD.
- `busy`=1 in LOAD, CHECK, STEP_UP and STEP_DN; 0 in IDLE and DONE.
- `start` while `busy` or in DONE is ignored, not queued.
- Step counter width: 6 bits, saturating. Arithmetic comparison is unsigned 5-bit.
- No wrap-around stepping: the driver never steps down from 0 or up from 31, because direction comes from the comparison against the target.

## Timing
- With `start` accepted at edge E0:
  - LOAD occupies cycle 1.
  - The first CHECK occurs in cycle 2.
  - Each step costs 2 cycles: STEP, then CHECK, which sees the updated `counter_fb`.
- `done` is asserted in cycle 3+2k, where k=|init_val−target|. Example: init 23, target 24 gives `done` in cycle 5.
- Minimum request-to-request spacing: the next `start` is accepted in the cycle after DONE.
- `counter_fb` must be the counter's registered output; the driver relies on a one-edge update after each strobe.
- Reset mid-operation: all outputs go to their reset values immediately, asynchronously. No `done` pulse is produced for the aborted request.

## Configuration
- `COUNTER_DRV_FLAG_CHECK_EN`, when defined:
  - In every CHECK cycle, the driver requires `low_fb == (counter_fb==0)` and `high_fb == (counter_fb==31)`.
  - Any mismatch goes to DONE with `error=1`. This check has priority over the target comparison.
- When not defined: `low_fb` and `high_fb` are unused, and `error` arises only from timeout.

## Test plan
- Load only: mode 11, `init_val`=10111.
  - `load` is high for one cycle in cycle 1.
  - `done=1`, `error=0` in cycle 3; `counter_fb`=10111.
- Step up: mode 00, init 10111, target 11000.
  - One `up` pulse.
  - `done`, no error, in cycle 5; `counter_fb`=11000.
- Sweep low: mode 01, init 10110.
  - 22 `down` pulses and no `up` pulses.
  - `done` in cycle 47 with `counter_fb`=0 and `low_fb`=1, `error=0`.
- Sweep high: mode 10, init 0.
  - 31 `up` pulses.
  - `done` in cycle 65 with `counter_fb`=31 and `high_fb`=1.
  - With `TIMEOUT`=10, the same request ends after 10 pulses with `done=1`, `error=1`.
- Flag fault, with `COUNTER_DRV_FLAG_CHECK_EN` defined: force `low_fb=1` while `counter_fb`=5 → `done` with `error=1` at the next CHECK.
- Reset mid-sweep: deassert `rst_n` while in STEP_UP.
  - All outputs read 0 in the same cycle, with no `done`.
  - After release, a `start` is accepted normally.
